fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction-fetch initiator that drives the byte-addressed, little-endian instruction memory (`imemory`) from the core side. It holds the fetch program counter, presents it on the memory address port, and captures the combinationally returned word with its PC into a 4-entry prefetch buffer. Decode drains the buffer through a valid/ready handshake. Branch and jump resolution redirects the PC and flushes the buffer.

## Interface
Parameters:
- `PC_RESET`, default `32'h01000000`: fetch PC after reset.
- `DEPTH`, default 4: prefetch buffer entries. The value is fixed at 4; no other depth is supported.

Ports:
- `clock`  in  1: single clock; all state updates on its rising edge.
- `reset`  in  1: synchronous, active-low. Sampled low at a rising edge, it initialises all state.
- `imem_address`  out  32: byte address to `imemory`. Equals fetch_pc, a register.
- `imem_data_in`  out  32: constant 0.
- `imem_read_write`  out  1: constant 0. This block never writes memory.
- `imem_data_out`  in  32: word read combinationally from `imemory` at `imem_address`.
- `redirect_valid`  in  1: load a new fetch PC and flush the buffer.
- `redirect_pc`  in  32: redirect target.
- `out_valid`  out  1: buffer head holds a valid entry.
- `out_pc`  out  32: PC of the head entry.
- `out_insn`  out  32: instruction word of the head entry.
- `out_ready`  in  1: consumer accepts the head this cycle.
- `buffer_count`  out  3: number of occupied entries, 0 to 4.
- `misalign_err`  out  1: sticky flag, set by a redirect with `redirect_pc[1:0] != 0`.

## Operation
- State:
  - fetch_pc, 32 bits.
  - 4-entry circular buffer of {pc, insn}.
  - Read pointer and write pointer, 2 bits each; both wrap 3 → 0.
  - count, 3 bits.
  - misalign_err.
- Pop: occurs when `out_valid && out_ready`. The read pointer advances.
- Push: occurs when `redirect_valid == 0` and (count < 4 or a pop occurs this cycle).
  - Writes {fetch_pc, `imem_data_out`} at the write pointer, then advances the write pointer.
  - fetch_pc ← fetch_pc + 4, modulo 2^32. `0xFFFFFFFC` wraps to `0x00000000`.
- count update:
  - Push only: +1.
  - Pop only: −1.
  - Push and pop together: unchanged. This includes the full-and-pop case, where the push is accepted.
- Redirect has priority over push:
  - fetch_pc ← {`redirect_pc`[31:2], 2'b00}.
  - count ← 0 and both pointers ← 0.
  - No push this cycle.
  - A pop handshake in the same cycle counts as consumed; the flush discards everything else.
- misalign_err ← 1 when `redirect_valid` is high and `redirect_pc[1:0] != 0`. Only reset clears it.
- Output mapping:
  - `out_valid` = (count != 0).
  - `out_pc` / `out_insn` = entry at the read pointer. When `out_valid` is 0 these values are don't-care for the consumer.
  - `buffer_count` = count.
- Reset values:
  - fetch_pc = `PC_RESET`, so `imem_address` = `PC_RESET`.
  - count = 0, pointers = 0, all buffer entries = 0.
  - So: `out_valid` = 0, `out_pc` = 0, `out_insn` = 0, `buffer_count` = 0, `misalign_err` = 0.
- Reset has priority over redirect, push and pop. Reset mid-operation discards all buffered entries.

## Timing
- No combinational path from any input to `imem_address`, `out_valid`, `out_pc`, `out_insn` or `buffer_count`. All are functions of registered state.
- `out_ready` affects only same-edge state updates.
- First rising edge with `reset` high pushes the `PC_RESET` entry. `out_valid` rises after that edge, so fetch latency is 1 cycle.
- Steady state with `out_ready` = 1: one instruction per cycle, consecutive PCs, no bubbles.
- Redirect asserted at edge E:
  - After E: `out_valid` = 0 and `imem_address` = target.
  - E+1 pushes the target entry.
  - After E+1: `out_valid` = 1 with `out_pc` = target.
  - Redirect-to-delivery is 2 edges.
- Back-to-back redirects: the last one wins. Each redirect suppresses that cycle's push.
- `imemory` is read combinationally. The pushed word is whatever `imem_data_out` shows in the cycle of the push edge.

## Test plan
- In-order stream:
  - Stimulus: reset with memory words at 0x01000000 = 0x00000013 and 0x01000004 = 0x00100093; hold `out_ready` = 1.
  - Required response: one cycle after reset release, `out_pc`/`out_insn` = 0x01000000/0x00000013, next cycle 0x01000004/0x00100093, then consecutive PCs every cycle with no gaps.
- Back-pressure:
  - Stimulus: hold `out_ready` = 0 for 10 cycles after reset.
  - Required response: `buffer_count` saturates at 4; `imem_address` holds 0x01000010; `out_pc` holds 0x01000000.
  - Then raise `out_ready`: PCs 0x01000000, 0x01000004, 0x01000008, … delivered with no duplicates or gaps.
- Full with simultaneous pop:
  - Stimulus: count = 4, `out_ready` pulsed high for one cycle.
  - Required response: push accepted, count stays 4, `imem_address` advances by 4.
- Flush on redirect:
  - Stimulus: buffer full; redirect to 0x01000100 in the same cycle as `out_ready` = 1.
  - Required response: next cycle `out_valid` = 0, `buffer_count` = 0, `imem_address` = 0x01000100. Following cycle `out_pc` = 0x01000100.
- Misaligned redirect:
  - Stimulus: redirect to 0x01000102.
  - Required response: fetch resumes at 0x01000100 and `misalign_err` = 1, held through later redirects until reset.
- PC wrap and mid-run reset:
  - Stimulus: redirect to 0xFFFFFFFC.
  - Required response: next delivered PCs are 0xFFFFFFFC, then 0x00000000.
  - Stimulus: assert `reset` low for one edge while the buffer is non-empty.
  - Required response: all outputs return to their reset values.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch initiator for the imemory port.
// Holds the fetch PC, pushes {pc, word} into a 4-entry prefetch buffer
// each cycle there is room, and hands the buffer head to decode through
// a valid/ready handshake. A redirect reloads the PC and flushes the buffer.
module fetch_unit #(
   parameter logic [31:0] PC_RESET = 32'h01000000,
   parameter int          DEPTH    = 4
) (
   input  logic        clock,
   input  logic        reset,
   output logic [31:0] imem_address,
   output logic [31:0] imem_data_in,
   output logic        imem_read_write,
   input  logic [31:0] imem_data_out,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        out_valid,
   output logic [31:0] out_pc,
   output logic [31:0] out_insn,
   input  logic        out_ready,
   output logic [2:0]  buffer_count,
   output logic        misalign_err
);

   // Buffer is full when count reaches the depth (fixed at 4, so 2-bit pointers).
   localparam logic [2:0] FULL_COUNT = 3'(DEPTH);

   logic [31:0] fetch_pc_reg, fetch_pc_next;
   logic [1:0]  rd_ptr_reg, rd_ptr_next;
   logic [1:0]  wr_ptr_reg, wr_ptr_next;
   logic [2:0]  count_reg, count_next;
   logic        misalign_reg, misalign_next;

   logic [31:0] pc_mem   [DEPTH];
   logic [31:0] insn_mem [DEPTH];

   logic             pop;
   logic             push;
   logic [DEPTH-1:0] entry_we;

   // A pop frees a slot on the same edge, so a full buffer still accepts a push
   // when the head is consumed. A redirect always suppresses the push.
   assign pop  = (count_reg != 3'd0) && out_ready;
   assign push = !redirect_valid && ((count_reg != FULL_COUNT) || pop);

   // Per-entry write enables decoded from the write pointer.
   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry_we
         assign entry_we[gi] = push && (wr_ptr_reg == 2'(gi));
      end
   endgenerate

   // Next-state: redirect takes priority and flushes; otherwise push/pop bookkeeping.
   always_comb begin
      fetch_pc_next = fetch_pc_reg;
      rd_ptr_next   = rd_ptr_reg;
      wr_ptr_next   = wr_ptr_reg;
      count_next    = count_reg;
      misalign_next = misalign_reg;
      if (redirect_valid) begin
         fetch_pc_next = {redirect_pc[31:2], 2'b00};
         rd_ptr_next   = 2'd0;
         wr_ptr_next   = 2'd0;
         count_next    = 3'd0;
         if (redirect_pc[1:0] != 2'b00) begin
            misalign_next = 1'b1;
         end
      end else begin
         if (pop) begin
            rd_ptr_next = rd_ptr_reg + 2'd1;
         end
         if (push) begin
            wr_ptr_next   = wr_ptr_reg + 2'd1;
            fetch_pc_next = fetch_pc_reg + 32'd4;
         end
         if (push && !pop) begin
            count_next = count_reg + 3'd1;
         end else if (pop && !push) begin
            count_next = count_reg - 3'd1;
         end
      end
   end

   // Control state register with synchronous active-low reset.
   always_ff @(posedge clock) begin
      if (!reset) begin
         fetch_pc_reg <= PC_RESET;
         rd_ptr_reg   <= 2'd0;
         wr_ptr_reg   <= 2'd0;
         count_reg    <= 3'd0;
         misalign_reg <= 1'b0;
      end else begin
         fetch_pc_reg <= fetch_pc_next;
         rd_ptr_reg   <= rd_ptr_next;
         wr_ptr_reg   <= wr_ptr_next;
         count_reg    <= count_next;
         misalign_reg <= misalign_next;
      end
   end

   // Buffer storage: entries are cleared on reset so the head reads as zero afterwards.
   always_ff @(posedge clock) begin
      for (int i = 0; i < DEPTH; i++) begin
         if (!reset) begin
            pc_mem[i]   <= 32'd0;
            insn_mem[i] <= 32'd0;
         end else if (entry_we[i]) begin
            pc_mem[i]   <= fetch_pc_reg;
            insn_mem[i] <= imem_data_out;
         end
      end
   end

   // Outputs are pure functions of registered state.
   assign imem_address    = fetch_pc_reg;
   assign imem_data_in    = 32'd0;
   assign imem_read_write = 1'b0;
   assign out_valid       = (count_reg != 3'd0);
   assign out_pc          = pc_mem[rd_ptr_reg];
   assign out_insn        = insn_mem[rd_ptr_reg];
   assign buffer_count    = count_reg;
   assign misalign_err    = misalign_reg;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed test-plan scenarios followed by random traffic,
// all checked against a queue-based reference model of the fetch buffer.
module tb_fetch_unit;

   logic        clock;
   logic        reset;
   logic [31:0] imem_address;
   logic [31:0] imem_data_in;
   logic        imem_read_write;
   logic [31:0] imem_data_out;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        out_valid;
   logic [31:0] out_pc;
   logic [31:0] out_insn;
   logic        out_ready;
   logic [2:0]  buffer_count;
   logic        misalign_err;

   int n_vec = 0;
   int n_err = 0;

   // Reference model state.
   logic [63:0] model_q[$];
   logic [31:0] model_pc;
   logic        model_mis;
   logic        model_fresh_reset;

   fetch_unit dut (
      .clock           (clock),
      .reset           (reset),
      .imem_address    (imem_address),
      .imem_data_in    (imem_data_in),
      .imem_read_write (imem_read_write),
      .imem_data_out   (imem_data_out),
      .redirect_valid  (redirect_valid),
      .redirect_pc     (redirect_pc),
      .out_valid       (out_valid),
      .out_pc          (out_pc),
      .out_insn        (out_insn),
      .out_ready       (out_ready),
      .buffer_count    (buffer_count),
      .misalign_err    (misalign_err)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Instruction memory contents: two fixed words, a scrambled pattern elsewhere.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == 32'h01000000) return 32'h00000013;
      if (a == 32'h01000004) return 32'h00100093;
      return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
   endfunction

   assign imem_data_out = mem_word(imem_address);

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Model one rising edge: reset, then redirect/flush, then pop-before-push.
   task automatic model_edge(input logic rst, input logic rdy, input logic rv, input logic [31:0] rpc);
      bit popped;
      model_fresh_reset = 1'b0;
      if (!rst) begin
         model_q.delete();
         model_pc          = 32'h01000000;
         model_mis         = 1'b0;
         model_fresh_reset = 1'b1;
      end else if (rv) begin
         model_q.delete();
         model_pc = {rpc[31:2], 2'b00};
         if (rpc[1:0] != 2'b00) model_mis = 1'b1;
      end else begin
         popped = (model_q.size() != 0) && rdy;
         if (popped) void'(model_q.pop_front());
         if (model_q.size() < 4) begin
            model_q.push_back({model_pc, mem_word(model_pc)});
            model_pc = model_pc + 32'd4;
         end
      end
   endtask

   task automatic compare_all();
      check("out_valid", {31'd0, out_valid}, {31'd0, model_q.size() != 0});
      check("buffer_count", {29'd0, buffer_count}, 32'(model_q.size()));
      check("imem_address", imem_address, model_pc);
      check("misalign_err", {31'd0, misalign_err}, {31'd0, model_mis});
      check("imem_read_write", {31'd0, imem_read_write}, 32'd0);
      check("imem_data_in", imem_data_in, 32'd0);
      if (model_q.size() != 0) begin
         check("out_pc", out_pc, model_q[0][63:32]);
         check("out_insn", out_insn, model_q[0][31:0]);
      end else if (model_fresh_reset) begin
         check("out_pc_reset", out_pc, 32'd0);
         check("out_insn_reset", out_insn, 32'd0);
      end
   endtask

   // Apply one cycle of inputs, advance the model with the edge, check #1 later.
   task automatic cycle(input logic rst, input logic rdy, input logic rv, input logic [31:0] rpc);
      reset          = rst;
      out_ready      = rdy;
      redirect_valid = rv;
      redirect_pc    = rpc;
      @(posedge clock);
      model_edge(rst, rdy, rv, rpc);
      #1;
      compare_all();
   endtask

   initial begin
      logic [31:0] rpc;
      reset          = 1'b0;
      out_ready      = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 32'd0;
      model_pc       = 32'h01000000;
      model_mis      = 1'b0;
      model_fresh_reset = 1'b0;

      // Reset, then in-order stream with out_ready held high.
      cycle(1'b0, 1'b1, 1'b0, 32'd0);
      cycle(1'b0, 1'b1, 1'b0, 32'd0);
      cycle(1'b1, 1'b1, 1'b0, 32'd0);
      check("first_pc", out_pc, 32'h01000000);
      check("first_insn", out_insn, 32'h00000013);
      cycle(1'b1, 1'b1, 1'b0, 32'd0);
      check("second_pc", out_pc, 32'h01000004);
      check("second_insn", out_insn, 32'h00100093);
      for (int i = 0; i < 6; i++) cycle(1'b1, 1'b1, 1'b0, 32'd0);

      // Back-pressure from reset: fill and hold.
      cycle(1'b0, 1'b0, 1'b0, 32'd0);
      for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, 1'b0, 32'd0);
      check("bp_addr", imem_address, 32'h01000010);
      check("bp_head", out_pc, 32'h01000000);
      check("bp_count", {29'd0, buffer_count}, 32'd4);
      // Full with a single pop pulse: push accepted, count stays 4.
      cycle(1'b1, 1'b1, 1'b0, 32'd0);
      check("full_pop_addr", imem_address, 32'h01000014);
      check("full_pop_count", {29'd0, buffer_count}, 32'd4);
      for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, 32'd0);
      for (int i = 0; i < 8; i++) cycle(1'b1, 1'b1, 1'b0, 32'd0);

      // Flush on redirect while full with a simultaneous pop.
      for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 1'b0, 32'd0);
      cycle(1'b1, 1'b1, 1'b1, 32'h01000100);
      check("flush_valid", {31'd0, out_valid}, 32'd0);
      check("flush_addr", imem_address, 32'h01000100);
      cycle(1'b1, 1'b1, 1'b0, 32'd0);
      check("redir_pc", out_pc, 32'h01000100);

      // Misaligned redirect: aligned fetch, sticky flag through later redirects.
      cycle(1'b1, 1'b1, 1'b1, 32'h01000102);
      check("mis_addr", imem_address, 32'h01000100);
      check("mis_flag", {31'd0, misalign_err}, 32'd1);
      cycle(1'b1, 1'b1, 1'b0, 32'd0);
      cycle(1'b1, 1'b1, 1'b1, 32'h02000000);
      cycle(1'b1, 1'b1, 1'b1, 32'h03000000);
      check("mis_sticky", {31'd0, misalign_err}, 32'd1);

      // PC wrap, then mid-run reset with a non-empty buffer.
      cycle(1'b1, 1'b0, 1'b1, 32'hFFFFFFFC);
      cycle(1'b1, 1'b0, 1'b0, 32'd0);
      check("wrap_pc0", out_pc, 32'hFFFFFFFC);
      cycle(1'b1, 1'b1, 1'b0, 32'd0);
      check("wrap_pc1", out_pc, 32'h00000000);
      cycle(1'b1, 1'b0, 1'b0, 32'd0);
      cycle(1'b0, 1'b1, 1'b1, 32'h12345677);
      check("rst_addr", imem_address, 32'h01000000);
      check("rst_mis", {31'd0, misalign_err}, 32'd0);

      // Random traffic: ready ~60%, redirects ~6%, occasional reset.
      for (int i = 0; i < 3000; i++) begin
         case ($urandom_range(0, 3))
            0: rpc = $urandom;
            1: rpc = 32'hFFFFFFF0 | 32'($urandom_range(0, 15));
            default: rpc = 32'h01000000 | 32'($urandom_range(0, 255));
         endcase
         cycle(($urandom_range(0, 199) != 0),
               ($urandom_range(0, 9) < 6),
               ($urandom_range(0, 99) < 6),
               rpc);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
